router_sync_n: RTL and testbench
================================

// Module: router_sync_n
// PURPOSE
//  Parametrised successor to the 3-port router synchroniser; sits between router FSM/register and NUM_CH output FIFOs.
//  - Decodes header address to a one-hot FIFO write enable.
//  - Returns the selected FIFO's full flag to the FSM.
//  - Drives one independent valid per channel.
//  - Issues a per-channel soft reset when a channel holds data unread for TIMEOUT consecutive cycles.
// PARAMETERS
//  NUM_CH   3   number of output channels/FIFOs, 1..(2**ADDR_W)
//  ADDR_W   2   width of header address field
//  TIMEOUT  30  stalled cycles before soft_reset pulse, >=2
//  CNT_W    $clog2(TIMEOUT+1)   localparam, per-channel counter width
// PORTS
//  clock          in   1          single clock, rising edge
//  resetn         in   1          asynchronous, active-low reset
//  detect_add     in   1          FSM: header address valid this cycle
//  addr           in   ADDR_W     header destination address
//  write_enb_reg  in   1          FSM: write payload/header to FIFO
//  read_enb       in   NUM_CH     per-channel FIFO read enable
//  empty          in   NUM_CH     per-channel FIFO empty
//  full           in   NUM_CH     per-channel FIFO full
//  write_enb      out  NUM_CH     one-hot FIFO write enable
//  fifo_full      out  1          full flag of selected channel
//  vld_out        out  NUM_CH     per-channel data valid
//  soft_reset     out  NUM_CH     per-channel 1-cycle soft-reset pulse
//  addr_err       out  1          only with ROUTER_SYNC_ADDR_ERR_EN
// BEHAVIOUR
//  Reset (resetn=0, async): addr_q=0, all counters=0, soft_reset=0, addr_err=0.
//  - During reset, combinational outputs follow their equations; write_enb=0 because write_enb_reg is low in reset.
//  Address capture: addr_q<=addr on each rising edge with detect_add=1; otherwise addr_q holds.
//  Address selection: sel = detect_add ? addr : addr_q (combinational bypass, zero latency).
//  - sel_ok = (sel < NUM_CH).
//  Write enable: write_enb = (write_enb_reg && sel_ok) ? (1<<sel) : 0.
//  - Never more than one bit set.
//  - Out-of-range address gives 0, so no write occurs.
//  fifo_full = sel_ok ? full[sel] : 1'b0 (combinational).
//  vld_out[i] = ~empty[i] for every i, with no priority between channels.
//  - Fixes the previous one-valid-at-a-time behaviour.
//  Timeout, one counter per channel (registered):
//  - stall[i] = ~empty[i] & ~read_enb[i].
//  - If !stall[i]: cnt[i]<=0, soft_reset[i]<=0.
//  - Else if cnt[i]==TIMEOUT-1: cnt[i]<=0, soft_reset[i]<=1 (pulse of exactly 1 cycle).
//  - Else: cnt[i]<=cnt[i]+1, soft_reset[i]<=0.
//  - So soft_reset[i] rises at the edge that completes the TIMEOUT-th consecutive stalled cycle.
//  - A read_enb or empty in any cycle restarts the count.
//  - Channels are fully independent; simultaneous timeouts pulse simultaneously.
//  - Counter never exceeds TIMEOUT-1; no wrap.
//  - Continued stall after a pulse restarts the count from 0 (next pulse TIMEOUT cycles later).
//  Reset mid-count: counters and pulses clear immediately and asynchronously.
// CONFIGURATION
//  ROUTER_SYNC_ADDR_ERR_EN defined:
//  - Port addr_err exists. It is a registered sticky flag.
//  - Set on the edge where detect_add=1 and addr>=NUM_CH.
//  - Cleared on the edge where detect_add=1 and addr<NUM_CH.
//  - Otherwise holds; reset value 0.
//  ROUTER_SYNC_ADDR_ERR_EN undefined: port and logic absent; out-of-range addresses are silently dropped as above.
// STRUCTURE
//  router_pkg: ROUTER_NUM_CH=3, ROUTER_ADDR_W=2, ROUTER_TIMEOUT=30 defaults; onehot function.
//  Sub-module router_sync_timer: one channel's counter plus pulse (ports clock, resetn, stall, soft_reset).
//  - Generated NUM_CH times.
//  Decode, select and valid logic stay in the top level.
// TESTING
//  1. Reset: resetn=0 mid-stall with cnt[1]=17 -> soft_reset=0 and cnt=0 immediately; after release, full 30 cycles needed for the pulse.
//  2. Decode: detect_add=1, addr=2, then write_enb_reg=1 for 4 cycles with addr changed to 0 -> write_enb=3'b100 throughout.
//     - Same test: full[2]=1 -> fifo_full=1; full[0]=1 alone -> fifo_full=0.
//  3. Timeout: empty[0]=0, read_enb[0]=0 held -> soft_reset[0]=1 for one cycle after the 30th edge, again after the 60th.
//     - Other soft_reset bits stay 0.
//  4. Near miss: stall 29 cycles, read_enb[0]=1 for 1 cycle, stall again -> no pulse until 30 further stalled cycles.
//  5. Parallel: empty=3'b000, read_enb=3'b010 -> vld_out=3'b111; soft_reset=3'b101 on the same cycle; bit1 never pulses.
//  6. Invalid address (NUM_CH=3): detect_add=1, addr=3, write_enb_reg=1 -> write_enb=0, fifo_full=0.
//     - With ROUTER_SYNC_ADDR_ERR_EN: addr_err=1 until the next detect_add with addr=1.

Source files
------------

// File: rtl/router_sync_n_pkg.sv
// Shared defaults and helpers for the parametrised router synchroniser.
package router_pkg;

  localparam int ROUTER_NUM_CH  = 3;
  localparam int ROUTER_ADDR_W  = 2;
  localparam int ROUTER_TIMEOUT = 30;

  // The decoder handles at most 32 channels; callers truncate the result to NUM_CH.
  localparam int ROUTER_IDX_W = 5;
  localparam int ROUTER_OH_W  = 32;

  function automatic logic [ROUTER_OH_W-1:0] onehot(input logic [ROUTER_IDX_W-1:0] idx);
    return ROUTER_OH_W'(1) << idx;
  endfunction

endpackage

// File: rtl/router_sync_n_if.sv
// FSM/FIFO-facing bus of router_sync_n; addr_err is present only with ROUTER_SYNC_ADDR_ERR_EN.
interface router_sync_n_if
  import router_pkg::*;
#(
  parameter int NUM_CH = ROUTER_NUM_CH,
  parameter int ADDR_W = ROUTER_ADDR_W
);

  logic              detect_add;
  logic [ADDR_W-1:0] addr;
  logic              write_enb_reg;
  logic [NUM_CH-1:0] read_enb;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] write_enb;
  logic              fifo_full;
  logic [NUM_CH-1:0] vld_out;
  logic [NUM_CH-1:0] soft_reset;
`ifdef ROUTER_SYNC_ADDR_ERR_EN
  logic              addr_err;
`endif

  modport master (
    output detect_add, addr, write_enb_reg, read_enb, empty, full,
    input  write_enb, fifo_full, vld_out, soft_reset
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    , input addr_err
`endif
  );

  modport slave (
    input  detect_add, addr, write_enb_reg, read_enb, empty, full,
    output write_enb, fifo_full, vld_out, soft_reset
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    , output addr_err
`endif
  );

endinterface

// File: rtl/router_sync_n_timer.sv
// One channel's stall counter: pulses soft_reset for one cycle after TIMEOUT stalled edges, registered.
module router_sync_timer #(
  parameter int TIMEOUT = 30
) (
  input  logic clock,
  input  logic resetn,
  input  logic stall,
  output logic soft_reset
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             soft_reset_q, soft_reset_d;

  always_comb begin
    cnt_d        = '0;
    soft_reset_d = 1'b0;
    if (stall) begin
      // Wrapping to zero on the pulse makes a continued stall time out again TIMEOUT cycles later.
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        soft_reset_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q        <= '0;
      soft_reset_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign soft_reset = soft_reset_q;

endmodule

// File: rtl/router_sync_n.sv
// Router synchroniser: zero-latency address decode/full select/valids, registered per-channel timeout pulses.
// No backpressure of its own; ROUTER_SYNC_ADDR_ERR_EN adds a sticky out-of-range address flag.
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_CH  = ROUTER_NUM_CH,
  parameter int ADDR_W  = ROUTER_ADDR_W,
  parameter int TIMEOUT = ROUTER_TIMEOUT
) (
  input logic            clock,
  input logic            resetn,
  router_sync_n_if.slave bus
);

  localparam logic [ADDR_W:0] NUM_CH_W = (ADDR_W + 1)'(NUM_CH);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] sel;
  logic              sel_ok;
  logic [NUM_CH-1:0] sel_oh;
  logic [NUM_CH-1:0] stall;
  logic [NUM_CH-1:0] pulse;

  // A header address in the current cycle overrides the captured one so the header itself is routed.
  always_comb begin
    sel    = bus.detect_add ? bus.addr : addr_q;
    sel_ok = ({1'b0, sel} < NUM_CH_W);
    sel_oh = NUM_CH'(onehot(ROUTER_IDX_W'(sel)));
    addr_d = sel;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign bus.write_enb = (bus.write_enb_reg && sel_ok) ? sel_oh : '0;
  assign bus.fifo_full = sel_ok && |(bus.full & sel_oh);
  assign bus.vld_out   = ~bus.empty;
  assign stall         = ~bus.empty & ~bus.read_enb;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    router_sync_timer #(
      .TIMEOUT (TIMEOUT)
    ) u_timer (
      .clock      (clock),
      .resetn     (resetn),
      .stall      (stall[i]),
      .soft_reset (pulse[i])
    );
  end

  assign bus.soft_reset = pulse;

`ifdef ROUTER_SYNC_ADDR_ERR_EN
  logic addr_err_q, addr_err_d;

  always_comb begin
    addr_err_d = bus.detect_add ? !sel_ok : addr_err_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.addr_err = addr_err_q;
`endif

endmodule

// File: tb/tb_router_sync_n.sv
// Directed table and timeout sequences for router_sync_n at NUM_CH=3, ADDR_W=2, TIMEOUT=30.
module tb_router_sync_n;

  logic clock;
  logic resetn;
  int   checks;
  int   errors;

  router_sync_n_if #(.NUM_CH(3), .ADDR_W(2)) bus ();

  router_sync_n #(.NUM_CH(3), .ADDR_W(2), .TIMEOUT(30)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       da;
    logic [1:0] addr;
    logic       wer;
    logic [2:0] empty;
    logic [2:0] full;
    logic [2:0] exp_we;
    logic       exp_ff;
    logic [2:0] exp_vld;
    logic       exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_stall(input int n, input logic [2:0] pulse, input string name);
    for (int k = 1; k <= n; k++) begin
      tick();
      chk(name, 32'(bus.soft_reset), 32'((k == n) ? pulse : 3'b000));
    end
  endtask

  task automatic clear_stall();
    bus.empty    = 3'b111;
    bus.read_enb = 3'b111;
    tick();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //           da  addr   wer  empty   full    we      ff    vld     err
    vecs[0] = '{1'b0, 2'd3, 1'b1, 3'b111, 3'b000, 3'b001, 1'b0, 3'b000, 1'b0};
    vecs[1] = '{1'b1, 2'd2, 1'b0, 3'b110, 3'b100, 3'b000, 1'b1, 3'b001, 1'b0};
    vecs[2] = '{1'b0, 2'd0, 1'b1, 3'b011, 3'b100, 3'b100, 1'b1, 3'b100, 1'b0};
    vecs[3] = '{1'b0, 2'd1, 1'b1, 3'b000, 3'b001, 3'b100, 1'b0, 3'b111, 1'b0};
    vecs[4] = '{1'b1, 2'd1, 1'b1, 3'b101, 3'b010, 3'b010, 1'b1, 3'b010, 1'b0};
    vecs[5] = '{1'b1, 2'd3, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000, 1'b1};
    vecs[6] = '{1'b0, 2'd0, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000, 1'b1};
    vecs[7] = '{1'b1, 2'd0, 1'b1, 3'b111, 3'b001, 3'b001, 1'b1, 3'b000, 1'b0};
    vecs[8] = '{1'b0, 2'd2, 1'b0, 3'b111, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0};

    resetn            = 1'b0;
    bus.detect_add    = 1'b0;
    bus.addr          = 2'd0;
    bus.write_enb_reg = 1'b0;
    bus.read_enb      = 3'b111;
    bus.empty         = 3'b110;
    bus.full          = 3'b000;
    #12;
    chk("rst_soft_reset", 32'(bus.soft_reset), 32'(3'b000));
    chk("rst_write_enb", 32'(bus.write_enb), 32'(3'b000));
    chk("rst_vld_out", 32'(bus.vld_out), 32'(3'b001));
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    chk("rst_addr_err", 32'(bus.addr_err), 32'(1'b0));
`endif
    resetn = 1'b1;
    bus.empty = 3'b111;
    tick();

    // Combinational decode table; addr_q carries over between rows.
    for (int i = 0; i < 9; i++) begin
      bus.detect_add    = vecs[i].da;
      bus.addr          = vecs[i].addr;
      bus.write_enb_reg = vecs[i].wer;
      bus.empty         = vecs[i].empty;
      bus.full          = vecs[i].full;
      bus.read_enb      = 3'b111;
      #1;
      chk($sformatf("tbl%0d_write_enb", i), 32'(bus.write_enb), 32'(vecs[i].exp_we));
      chk($sformatf("tbl%0d_fifo_full", i), 32'(bus.fifo_full), 32'(vecs[i].exp_ff));
      chk($sformatf("tbl%0d_vld_out", i), 32'(bus.vld_out), 32'(vecs[i].exp_vld));
      tick();
`ifdef ROUTER_SYNC_ADDR_ERR_EN
      chk($sformatf("tbl%0d_addr_err", i), 32'(bus.addr_err), 32'(vecs[i].exp_err));
`endif
    end

    // Decode hold: addr 2 captured, later addr changes are ignored.
    bus.empty = 3'b111;
    bus.detect_add = 1'b1;
    bus.addr = 2'd2;
    bus.write_enb_reg = 1'b0;
    bus.full = 3'b100;
    #1;
    chk("hold_ff_bypass", 32'(bus.fifo_full), 32'(1'b1));
    tick();
    bus.detect_add = 1'b0;
    bus.addr = 2'd0;
    bus.write_enb_reg = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("hold_we%0d", k), 32'(bus.write_enb), 32'(3'b100));
      chk($sformatf("hold_ff%0d", k), 32'(bus.fifo_full), 32'(1'b1));
      tick();
    end
    bus.full = 3'b001;
    #1;
    chk("hold_ff_other_full", 32'(bus.fifo_full), 32'(1'b0));
    chk("hold_we_after", 32'(bus.write_enb), 32'(3'b100));

    // Invalid address is dropped; sticky error until a valid header.
    tick();
    bus.detect_add = 1'b1;
    bus.addr = 2'd3;
    bus.full = 3'b111;
    #1;
    chk("inv_write_enb", 32'(bus.write_enb), 32'(3'b000));
    chk("inv_fifo_full", 32'(bus.fifo_full), 32'(1'b0));
    tick();
    bus.detect_add = 1'b0;
    bus.addr = 2'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("inv_hold_we%0d", k), 32'(bus.write_enb), 32'(3'b000));
`ifdef ROUTER_SYNC_ADDR_ERR_EN
      chk($sformatf("inv_err_hold%0d", k), 32'(bus.addr_err), 32'(1'b1));
`endif
      tick();
    end
    bus.detect_add = 1'b1;
    bus.addr = 2'd1;
    tick();
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    chk("inv_err_cleared", 32'(bus.addr_err), 32'(1'b0));
`endif
    bus.detect_add = 1'b0;
    bus.write_enb_reg = 1'b0;
    bus.full = 3'b000;

    // Timeout on channel 0, twice.
    clear_stall();
    bus.empty = 3'b110;
    bus.read_enb = 3'b110;
    run_stall(30, 3'b001, "to_first");
    run_stall(30, 3'b001, "to_second");

    // Near miss: one read after 29 stalled cycles restarts the count.
    clear_stall();
    bus.empty = 3'b110;
    bus.read_enb = 3'b110;
    run_stall(29, 3'b000, "near_pre");
    bus.read_enb = 3'b111;
    tick();
    chk("near_read", 32'(bus.soft_reset), 32'(3'b000));
    bus.read_enb = 3'b110;
    run_stall(30, 3'b001, "near_post");

    // Parallel channels: 0 and 2 stall, 1 is read every cycle.
    clear_stall();
    bus.empty = 3'b000;
    bus.read_enb = 3'b010;
    #1;
    chk("par_vld_out", 32'(bus.vld_out), 32'(3'b111));
    run_stall(30, 3'b101, "par_first");
    run_stall(30, 3'b101, "par_second");

    // Asynchronous reset clears a live pulse and a partial count.
    clear_stall();
    bus.empty = 3'b101;
    bus.read_enb = 3'b101;
    run_stall(30, 3'b010, "rst_pre_pulse");
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_clears_pulse", 32'(bus.soft_reset), 32'(3'b000));
    tick();
    resetn = 1'b1;
    run_stall(17, 3'b000, "rst_cnt17");
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_mid_count", 32'(bus.soft_reset), 32'(3'b000));
    tick();
    chk("rst_held0", 32'(bus.soft_reset), 32'(3'b000));
    tick();
    chk("rst_held1", 32'(bus.soft_reset), 32'(3'b000));
    resetn = 1'b1;
    run_stall(30, 3'b010, "rst_full_count");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
